// File: rtl/mem_access_if.sv
// mem_access_if -- bundle of the three handshake groups seen by mem_access.
//   req_*  : core -> unit load/store request (valid/ready)
//   mem_*  : unit -> memory word-wide request, memory -> unit read return
//   rsp_*  : unit -> core response (valid/ready)
// Modports:
//   slave  : the load/store unit's view (accepts requests, drives memory)
//   master : the environment's view (core plus memory model)
interface mem_access_if #(
    parameter int DWIDTH = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic [DWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;

    logic              mem_en;
    logic              mem_ready;
    logic [DWIDTH-3:0] mem_addr;
    logic [3:0]        mem_be;
    logic [DWIDTH-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DWIDTH-1:0] mem_rdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_misaligned;

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        input  rsp_ready,
        output req_ready,
        output mem_en, mem_addr, mem_be, mem_wdata,
        output rsp_valid, rsp_rdata, rsp_misaligned
    );

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        output rsp_ready,
        input  req_ready,
        input  mem_en, mem_addr, mem_be, mem_wdata,
        input  rsp_valid, rsp_rdata, rsp_misaligned
    );
endinterface

// File: rtl/mem_access.sv
// mem_access -- single-outstanding load/store unit between a core and a
// word-addressed memory.  Byte/half/word accesses are checked for alignment,
// stores get byte enables and lane-replicated data, loads return the memory
// word shifted down so the addressed byte sits at bit 0 (zero-filled).
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_access_if.slave (req_*, mem_*, rsp_* groups)
// Every output except req_ready is a register; req_ready is decoded from the
// state register (and is held low while rst is asserted).
module mem_access #(
    parameter int DWIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    mem_access_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q;
    logic                we_q;
    logic [1:0]          off_q;
    logic                mem_en_q;
    logic [DWIDTH-3:0]   mem_addr_q;
    logic [3:0]          mem_be_q;
    logic [DWIDTH-1:0]   mem_wdata_q;
    logic                rsp_valid_q;
    logic [DWIDTH-1:0]   rsp_rdata_q;
    logic                rsp_mis_q;

    // Request decode: only consumed by registers on the accept edge.
    logic                misaligned_d;
    logic [3:0]          be_d;
    logic [DWIDTH-1:0]   wdata_d;
    logic [DWIDTH-1:0]   rdata_shift_d;

    always_comb begin
        misaligned_d = 1'b0;
        be_d         = 4'b0000;
        wdata_d      = '0;
        case (bus.req_size)
            2'd0: begin
                be_d    = 4'b0001 << bus.req_addr[1:0];
                wdata_d = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                misaligned_d = bus.req_addr[0];
                be_d         = 4'b0011 << {bus.req_addr[1], 1'b0};
                wdata_d      = {2{bus.req_wdata[15:0]}};
            end
            2'd2: begin
                misaligned_d = |bus.req_addr[1:0];
                be_d         = 4'b1111;
                wdata_d      = bus.req_wdata;
            end
            default: begin
                misaligned_d = 1'b1;
            end
        endcase
        // Loads never write: no enables, no data on the bus.
        if (!bus.req_we) begin
            be_d    = 4'b0000;
            wdata_d = '0;
        end
    end

    // Byte offset of the access selects how far the read word moves down.
    always_comb begin
        rdata_shift_d = bus.mem_rdata >> {off_q, 3'b000};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            off_q       <= 2'b00;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_mis_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // req_ready is high exactly in IDLE outside reset.
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        off_q       <= bus.req_addr[1:0];
                        rsp_rdata_q <= '0;
                        if (misaligned_d) begin
                            // Abort without touching memory.
                            rsp_mis_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            rsp_mis_q   <= 1'b0;
                            mem_en_q    <= 1'b1;
                            mem_addr_q  <= bus.req_addr[DWIDTH-1:2];
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready) begin
                        mem_en_q <= 1'b0;
                        if (we_q) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        rsp_rdata_q <= rdata_shift_d;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready      = (state_q == IDLE) && !rst;
    assign bus.mem_en         = mem_en_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_be         = mem_be_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_rdata      = rsp_rdata_q;
    assign bus.rsp_misaligned = rsp_mis_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access -- bench for mem_access.  The bench plays both the core and
// the memory; inputs are driven and outputs sampled on the falling edge.
// A fixed vector table carries literal expectations, a randomized run uses a
// small arithmetic reference model, and a hand-written sequence covers reset
// in the middle of a load.
module tb_mem_access;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_access_if #(.DWIDTH(32)) bus ();

    mem_access #(.DWIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          md;
        int          rd;
        int          sd;
        logic [31:0] e_rdata;
        logic        e_mis;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        int          e_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int md, input int rd,
                           input int sd, input logic [31:0] e_rdata, input logic e_mis,
                           input logic [3:0] e_be, input logic [31:0] e_wdata,
                           input int e_lat);
        vec_t v;
        v.name = name; v.we = we; v.size = size; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.md = md; v.rd = rd; v.sd = sd; v.e_rdata = e_rdata;
        v.e_mis = e_mis; v.e_be = e_be; v.e_wdata = e_wdata; v.e_lat = e_lat;
        vecs.push_back(v);
    endtask

    // Reference model straight from the access rules: natural alignment,
    // enables covering the accessed bytes, data repeated across lanes,
    // read word divided down to the addressed byte.
    task automatic model(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int md, input int rd,
                         output logic [31:0] e_rdata, output logic e_mis,
                         output logic [3:0] e_be, output logic [31:0] e_wdata,
                         output int e_lat);
        int nbytes;
        int off;
        int be_i;
        nbytes  = 1 << size;
        off     = int'(addr % 4);
        e_mis   = (size == 2'd3) || ((addr % nbytes) != 0);
        be_i    = ((1 << nbytes) - 1) << off;
        e_be    = (we && !e_mis) ? be_i[3:0] : 4'b0000;
        e_wdata = '0;
        for (int l = 0; l < 4; l++) begin
            e_wdata[8*l +: 8] = wdata[8*(l % nbytes) +: 8];
        end
        e_rdata = (!we && !e_mis) ? (rdata >> (8 * off)) : 32'h0;
        if (e_mis)   e_lat = 1;
        else if (we) e_lat = 2 + md;
        else         e_lat = 3 + md + rd;
    endtask

    task automatic clear_drv();
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        bus.rsp_ready  = 1'b0;
    endtask

    // One full transaction; the bench answers as memory with md cycles of
    // mem_ready delay and rd cycles of read delay, and holds off rsp_ready
    // for sd cycles.  Called at a falling edge, returns at a falling edge.
    task automatic do_txn(input vec_t v);
        int k;
        int lat = 0;
        int mem_wait = 0;
        int rv_wait = 0;
        int rsp_wait = 0;
        int unstable_mem = 0;
        int unstable_rsp = 0;
        int rdy_high = 0;
        int mem_cycles = 0;
        bit seen_mem = 0;
        bit seen_rsp = 0;
        bit in_wait = 0;
        bit consumed = 0;
        bit done = 0;
        logic [29:0] a0 = '0;
        logic [3:0]  b0 = '0;
        logic [31:0] w0 = '0;
        logic [31:0] r0 = '0;
        logic        m0 = 1'b0;

        k = 0;
        while (bus.req_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({v.name, ".req_ready"}, {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_size  = v.size;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        k = 1;
        while (!done && k <= 40) begin
            clear_drv();
            if (bus.req_ready === 1'b1) rdy_high++;
            if (in_wait) begin
                if (rv_wait == v.rd) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = v.rdata;
                    in_wait        = 0;
                end else begin
                    rv_wait++;
                end
            end
            if (bus.mem_en === 1'b1) begin
                mem_cycles++;
                if (!seen_mem) begin
                    seen_mem = 1;
                    a0 = bus.mem_addr;
                    b0 = bus.mem_be;
                    w0 = bus.mem_wdata;
                end else if (bus.mem_addr !== a0 || bus.mem_be !== b0 || bus.mem_wdata !== w0) begin
                    unstable_mem++;
                end
                if (mem_wait == v.md) begin
                    bus.mem_ready = 1'b1;
                    in_wait = !v.we;
                end else begin
                    mem_wait++;
                    // Read return outside WAIT must be ignored.
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = 32'hDEADBEEF;
                end
            end
            if (bus.rsp_valid === 1'b1) begin
                if (!seen_rsp) begin
                    seen_rsp = 1;
                    lat = k;
                    r0  = bus.rsp_rdata;
                    m0  = bus.rsp_misaligned;
                end else if (bus.rsp_rdata !== r0 || bus.rsp_misaligned !== m0) begin
                    unstable_rsp++;
                end
                if (rsp_wait == v.sd) begin
                    bus.rsp_ready = 1'b1;
                    consumed = 1;
                end else begin
                    rsp_wait++;
                end
            end
            @(negedge clk);
            k++;
            if (consumed) done = 1;
        end
        clear_drv();
        chk({v.name, ".completed"}, {31'b0, done}, 32'd1);
        chk({v.name, ".latency"}, lat, v.e_lat);
        chk({v.name, ".rsp_rdata"}, r0, v.e_rdata);
        chk({v.name, ".rsp_mis"}, {31'b0, m0}, {31'b0, v.e_mis});
        if (v.e_mis) begin
            chk({v.name, ".mem_en_cycles"}, mem_cycles, 32'd0);
        end else begin
            chk({v.name, ".mem_en_cycles"}, mem_cycles, v.md + 1);
            chk({v.name, ".mem_addr"}, {2'b0, a0}, {2'b0, v.addr[31:2]});
            chk({v.name, ".mem_be"}, {28'b0, b0}, {28'b0, v.e_be});
            if (v.we) chk({v.name, ".mem_wdata"}, w0, v.e_wdata);
        end
        chk({v.name, ".mem_stable"}, unstable_mem, 32'd0);
        chk({v.name, ".rsp_stable"}, unstable_rsp, 32'd0);
        chk({v.name, ".busy_ready"}, rdy_high, 32'd0);
        chk({v.name, ".rsp_dropped"}, {31'b0, bus.rsp_valid}, 32'd0);
        chk({v.name, ".idle_ready"}, {31'b0, bus.req_ready}, 32'd1);
        $display("TXN %s we=%0d size=%0d addr=%08h lat=%0d rdata=%08h mis=%0d",
                 v.name, v.we, v.size, v.addr, lat, r0, m0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        vec_t v;

        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'd0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        clear_drv();

        //       name          we    size   addr          wdata         rdata         md rd sd  e_rdata       mis   be       e_wdata       lat
        add_vec("ldb_1003",   1'b0, 2'd0, 32'h0000_1003, 32'h0,        32'hAABBCCDD, 0, 0, 0, 32'h000000AA, 1'b0, 4'b0000, 32'h0,        3);
        add_vec("sth_2002",   1'b1, 2'd1, 32'h0000_2002, 32'h0000_1234, 32'h0,       0, 0, 0, 32'h0,        1'b0, 4'b1100, 32'h12341234, 2);
        add_vec("ldw_3001",   1'b0, 2'd2, 32'h0000_3001, 32'h0,        32'h12345678, 0, 0, 0, 32'h0,        1'b1, 4'b0000, 32'h0,        1);
        add_vec("ld_sz3",     1'b0, 2'd3, 32'h0000_4000, 32'h0,        32'h12345678, 0, 0, 0, 32'h0,        1'b1, 4'b0000, 32'h0,        1);
        add_vec("st_sz3",     1'b1, 2'd3, 32'h0000_5003, 32'hFFFF_FFFF, 32'h0,       0, 0, 0, 32'h0,        1'b1, 4'b0000, 32'h0,        1);
        add_vec("stb_6001",   1'b1, 2'd0, 32'h0000_6001, 32'h0000_00AB, 32'h0,       0, 0, 0, 32'h0,        1'b0, 4'b0010, 32'hABABABAB, 2);
        add_vec("stw_7000",   1'b1, 2'd2, 32'h0000_7000, 32'hCAFE_F00D, 32'h0,       0, 0, 0, 32'h0,        1'b0, 4'b1111, 32'hCAFEF00D, 2);
        add_vec("ldh_8001",   1'b0, 2'd1, 32'h0000_8001, 32'h0,        32'h12345678, 0, 0, 0, 32'h0,        1'b1, 4'b0000, 32'h0,        1);
        add_vec("stw_stall",  1'b1, 2'd2, 32'h0000_9000, 32'h1357_9BDF, 32'h0,       3, 0, 2, 32'h0,        1'b0, 4'b1111, 32'h13579BDF, 5);
        add_vec("ldw_stall",  1'b0, 2'd2, 32'h0000_A000, 32'h0,        32'h55AA55AA, 2, 3, 1, 32'h55AA55AA, 1'b0, 4'b0000, 32'h0,        8);
        add_vec("ldb_off0",   1'b0, 2'd0, 32'h0000_C000, 32'h0,        32'h11223344, 0, 0, 0, 32'h11223344, 1'b0, 4'b0000, 32'h0,        3);
        add_vec("ldb_off1",   1'b0, 2'd0, 32'h0000_C001, 32'h0,        32'h11223344, 0, 0, 0, 32'h00112233, 1'b0, 4'b0000, 32'h0,        3);
        add_vec("ldb_off2",   1'b0, 2'd0, 32'h0000_C002, 32'h0,        32'h11223344, 0, 0, 0, 32'h00001122, 1'b0, 4'b0000, 32'h0,        3);
        add_vec("ldb_off3",   1'b0, 2'd0, 32'h0000_C003, 32'h0,        32'h11223344, 0, 0, 0, 32'h00000011, 1'b0, 4'b0000, 32'h0,        3);
        add_vec("ldh_off0",   1'b0, 2'd1, 32'h0000_C000, 32'h0,        32'h11223344, 0, 0, 0, 32'h11223344, 1'b0, 4'b0000, 32'h0,        3);
        add_vec("ldh_off2",   1'b0, 2'd1, 32'h0000_C002, 32'h0,        32'h11223344, 0, 0, 0, 32'h00001122, 1'b0, 4'b0000, 32'h0,        3);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst.req_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("rst.mem_en", {31'b0, bus.mem_en}, 32'd0);
        chk("rst.mem_be", {28'b0, bus.mem_be}, 32'd0);
        chk("rst.mem_addr", {2'b0, bus.mem_addr}, 32'd0);
        chk("rst.mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst.rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst.rsp_mis", {31'b0, bus.rsp_misaligned}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst.ready_after", {31'b0, bus.req_ready}, 32'd1);
        $display("TXN reset released req_ready=%0d", bus.req_ready);

        // Directed table, issued back to back.
        for (int i = 0; i < vecs.size(); i++) begin
            do_txn(vecs[i]);
        end

        // Reset while waiting for read data, stale read data afterwards.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h0000_B000;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rstwait.mem_en", {31'b0, bus.mem_en}, 32'd1);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstwait.ready_in_rst", {31'b0, bus.req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h87654321;
        #1;
        chk("rstwait.ready_after", {31'b0, bus.req_ready}, 32'd1);
        chk("rstwait.mem_en", {31'b0, bus.mem_en}, 32'd0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            if (bus.rsp_valid !== 1'b0) seen++;
        end
        chk("rstwait.no_rsp", seen, 32'd0);
        chk("rstwait.rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rstwait.idle_ready", {31'b0, bus.req_ready}, 32'd1);
        $display("TXN reset_in_wait rsp_valid_cycles=%0d req_ready=%0d", seen, bus.req_ready);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            v.name  = $sformatf("rnd%0d", i);
            v.we    = 1'($urandom_range(0, 1));
            v.size  = 2'($urandom_range(0, 3));
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.md    = $urandom_range(0, 2);
            v.rd    = $urandom_range(0, 2);
            v.sd    = $urandom_range(0, 2);
            model(v.we, v.size, v.addr, v.wdata, v.rdata, v.md, v.rd,
                  v.e_rdata, v.e_mis, v.e_be, v.e_wdata, v.e_lat);
            do_txn(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter: DWIDTH, 32, data/address width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 req_valid  input  1  core has a load/store request.
REQ-005 req_ready  output  1  unit can accept a request (high only in IDLE).
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  0 byte, 1 half, 2 word, 3 illegal.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 mem_en  output  1  memory request strobe.
REQ-011 mem_ready  input  1  memory accepts the request this cycle.
REQ-012 mem_addr  output  30  word address (addr[31:2]).
REQ-013 mem_be  output  4  byte enables, stores only; 0 for loads.
REQ-014 mem_wdata  output  32  lane-replicated store data.
REQ-015 mem_rvalid  input  1  mem_rdata valid; sampled only in WAIT.
REQ-016 mem_rdata  input  32  raw read word.
REQ-017 rsp_valid  output  1  response available.
REQ-018 rsp_ready  input  1  core consumes the response.
REQ-019 rsp_rdata  output  32  load data shifted to bit 0, zero-filled; sign/width selection is done downstream by loadmux using ld_sel from control_signals.vh.
REQ-020 rsp_misaligned  output  1  request aborted as misaligned/illegal.

Function
REQ-021 FSM states IDLE, ISSUE, WAIT, RESP; one request in flight.
REQ-022 IDLE: req_valid && req_ready -> latch we, size, addr, wdata; misaligned -> RESP, else -> ISSUE.
REQ-023 Misaligned: size 1 with addr[0]=1; size 2 with addr[1:0]!=0; size 3 always; no memory access issued.
REQ-024 ISSUE: mem_en=1, mem_addr/mem_be/mem_wdata held stable until mem_ready; on mem_ready: store -> RESP, load -> WAIT.
REQ-025 WAIT: on mem_rvalid capture rsp_rdata = mem_rdata >> (8*addr[1:0]) -> RESP; mem_rvalid in any other state ignored.
REQ-026 RESP: rsp_valid=1, rsp_rdata/rsp_misaligned held stable until rsp_ready; then IDLE; new request accepted no earlier than the cycle after.
REQ-027 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<(2*addr[1]); word 4'b1111.
REQ-028 Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-029 rsp_rdata = 0 for stores and misaligned responses; rsp_misaligned = 0 for all aligned responses.
REQ-030 Minimum latency (mem_ready and mem_rvalid asserted immediately): load accept cycle N -> rsp_valid N+3; store N+2; misaligned N+1.
REQ-031 All outputs registered or decoded from registered state only; no combinational path from req_* or mem_* inputs to any output.

Reset
REQ-032 rst high at a clock edge -> state IDLE, mem_en=0, mem_be=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_misaligned=0.
REQ-033 req_ready=0 while rst is high; 1 from the first cycle after rst deasserts.
REQ-034 Reset mid-transaction (ISSUE/WAIT/RESP) abandons it: no rsp_valid is produced; a later mem_rvalid is ignored.

Verification
REQ-035 Load byte addr 0x0000_1003, mem_rdata 0xAABBCCDD -> mem_addr 0x400, mem_be 0, rsp_rdata 0x000000AA at cycle N+3; loadmux LD_BYTE -> 0xFFFFFFAA.
REQ-036 Store half addr 0x0000_2002, wdata 0x0000_1234 -> mem_be 4'b1100, mem_wdata 0x12341234, rsp_valid at N+2 with rsp_rdata 0.
REQ-037 Load word addr 0x0000_3001 -> mem_en stays 0, rsp_valid with rsp_misaligned=1 at N+1; size=3 at any addr gives the same response.
REQ-038 mem_ready low 3 cycles, then rsp_ready low 2 cycles -> mem_* and rsp_* stable throughout, req_ready 0 until the response is consumed.
REQ-039 rst pulsed in WAIT, then mem_rvalid one cycle later -> IDLE with req_ready 1, rsp_valid never asserted.
REQ-040 Back-to-back loads at offsets 0..3 of word 0x11223344 -> rsp_rdata 0x11223344, 0x00112233, 0x00001122, 0x00000011 (byte size); half size at offsets 0 and 2 -> 0x11223344, 0x00001122.
